traj_ring_overlay: RTL and testbench
====================================

// Module: traj_ring_overlay
// PURPOSE
//  Parametrised successor of the per-pixel trajectory adder.
//  Keeps the last DEPTH tracked points in a ring buffer and paints a LINE_W-square box at each
//  point onto the VGA pixel stream. Each box fades with its age in frames and expires after
//  LIFE_FRAMES. Sits between the frame renderer and the VGA encoder.
//  Replaces the 640x480 flag array with DEPTH compare slots.
// PARAMETERS
//  H_BITS       10          horizontal coordinate width
//  V_BITS       10          vertical coordinate width
//  COLOR_W      30          pixel colour width {R10,G10,B10}
//  DEPTH        16          ring entries, power of two, 2..64
//  LINE_W       3           box extent: covers p..p+LINE_W on both axes
//  LIFE_FRAMES  63          entry expires when its frame age reaches this value (1..255)
//  TRAJ_COLOR   {10'd0,10'd800,10'd0}   full-intensity trail colour
// PORTS
//  i_clk         in   1        clock
//  i_rst_n       in   1        synchronous active-low reset
//  i_color       in   COLOR_W  background pixel for (i_h,i_v)
//  i_h           in   H_BITS   current pixel column
//  i_v           in   V_BITS   current pixel row
//  i_rendering   in   1        1 = active video, overlay enabled
//  i_frame_tick  in   1        1-cycle pulse, once per frame, during blanking
//  i_pointH      in   H_BITS   new point column
//  i_pointV      in   V_BITS   new point row
//  i_pointVAL    in   1        1-cycle strobe: push (i_pointH,i_pointV)
//  i_clear       in   1        drop every entry
//  o_color       out  COLOR_W  output pixel, registered
//  o_count       out  $clog2(DEPTH)+1  number of valid entries
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge):
//   - all entries invalid; wr_ptr=0; o_count=0; o_color=0.
//   - Reset mid-frame takes effect at the next edge.
//  Push (i_pointVAL=1):
//   - The entry at wr_ptr gets the coordinates, age=0 and valid=1.
//   - wr_ptr increments mod DEPTH. o_count saturates at DEPTH.
//   - Full ring: the oldest entry is overwritten and o_count stays DEPTH.
//  Dedup:
//   - The push coordinates equal the newest valid entry: no new entry is written and
//     wr_ptr does not move. The newest entry's age resets to 0.
//  Frame tick:
//   - Every valid entry's age increments, saturating at 255.
//   - An entry whose new age equals LIFE_FRAMES becomes invalid and o_count decrements.
//   - Expiry happens in ring order, so o_count always equals the number of valid slots.
//  Simultaneous events, priority clear > push > tick:
//   - clear with push or tick: all entries invalid, push dropped, o_count=0, wr_ptr=0.
//   - push with tick: the pushed entry gets age 0; every other entry ages.
//  Hit test:
//   - Entry k hits when i_h in [Hk, Hk+LINE_W] and i_v in [Vk, Vk+LINE_W].
//   - Compare in H_BITS+1 / V_BITS+1 bits so that boxes at the frame edge do not wrap.
//   - When several entries hit, the youngest (smallest age; tie goes to the most recent
//     write) selects the colour.
//  Fade:
//   - bucket = age*4/LIFE_FRAMES, in range 0..3.
//   - Trail colour = each TRAJ_COLOR channel >> bucket.
//  Output:
//   - o_color <= (i_rendering && hit) ? faded : i_color.
//   - Latency exactly 1 cycle; o_color is registered every cycle.
//   - The push and tick updates are visible to hit testing from the cycle after they happen.
// STRUCTURE
//  Package traj_pkg:
//   - H_BITS and V_BITS defaults, COLOR_W, the colour_t struct {r,g,b}, TRAJ_COLOR_DEF.
//   - function fade(colour_t, bucket).
//  Sub-module traj_slot, one per entry (generate):
//   - holds valid/H/V/age.
//   - inputs: load, refresh, tick, clear.
//   - outputs: hit, age, valid.
//  Top level:
//   - holds wr_ptr, the dedup compare, the youngest-hit priority select and the output register.
// TESTING
//  1. Reset, then push (100,50), render (i_h,i_v)=(102,53) -> next cycle o_color=TRAJ_COLOR;
//     pixel (104,50) -> o_color=i_color.
//  2. Push 17 distinct points with DEPTH=16 -> o_count=16, the first point no longer hits,
//     points 2..17 hit.
//  3. Push (10,10), then 16 frame ticks with LIFE_FRAMES=63 -> bucket 1, green=400;
//     after 63 ticks -> no hit, o_count=0.
//  4. Push (637,478) and render (0,478) and (639,479) -> no hit at (0,478) (no wrap),
//     hit at (639,479).
//  5. Push and i_clear in the same cycle, then render the pushed point -> no hit, o_count=0.
//  6. Push (5,5) twice with a tick in between -> o_count=1, age 0, full colour;
//     i_rendering=0 -> o_color=i_color.

Source files
------------

// File: rtl/traj_pkg.sv
// Shared types and helpers for the trajectory ring overlay.
package traj_pkg;

  localparam int unsigned H_BITS_DEF  = 10;
  localparam int unsigned V_BITS_DEF  = 10;
  localparam int unsigned CH_W        = 10;
  localparam int unsigned COLOR_W_DEF = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } colour_t;

  localparam colour_t TRAJ_COLOR_DEF = '{r: 10'd0, g: 10'd800, b: 10'd0};

  // Older boxes are dimmed by halving each channel once per age bucket.
  function automatic colour_t fade(input colour_t c, input logic [1:0] bucket);
    colour_t f;
    f.r = c.r >> bucket;
    f.g = c.g >> bucket;
    f.b = c.b >> bucket;
    return f;
  endfunction

endpackage

// File: rtl/traj_slot.sv
// One ring entry: stored point, frame age, validity and the box hit test.
module traj_slot #(
  parameter int unsigned H_BITS      = 10,
  parameter int unsigned V_BITS      = 10,
  parameter int unsigned LINE_W      = 3,
  parameter int unsigned LIFE_FRAMES = 63
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_refresh,
  input  logic              i_tick,
  input  logic [H_BITS-1:0] i_load_h,
  input  logic [V_BITS-1:0] i_load_v,
  input  logic [H_BITS-1:0] i_h,
  input  logic [V_BITS-1:0] i_v,
  output logic              o_hit,
  output logic [7:0]        o_age,
  output logic              o_valid,
  output logic [H_BITS-1:0] o_h,
  output logic [V_BITS-1:0] o_v
);

  logic              r_valid;
  logic [7:0]        r_age;
  logic [H_BITS-1:0] r_h;
  logic [V_BITS-1:0] r_v;
  logic [7:0]        w_age_inc;
  logic [H_BITS:0]   w_h_lo, w_h_hi, w_h_px;
  logic [V_BITS:0]   w_v_lo, w_v_hi, w_v_px;

  assign w_age_inc = (r_age == 8'hFF) ? r_age : r_age + 8'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_age   <= '0;
      r_h     <= '0;
      r_v     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_age   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_age   <= '0;
      r_h     <= i_load_h;
      r_v     <= i_load_v;
    end else if (i_refresh) begin
      r_age <= '0;
    end else if (i_tick && r_valid) begin
      r_age <= w_age_inc;
      if (w_age_inc == 8'(LIFE_FRAMES)) r_valid <= 1'b0;
    end
  end

  // One extra bit keeps boxes near the coordinate limit from wrapping to column/row 0.
  assign w_h_lo = {1'b0, r_h};
  assign w_h_hi = w_h_lo + (H_BITS + 1)'(LINE_W);
  assign w_h_px = {1'b0, i_h};
  assign w_v_lo = {1'b0, r_v};
  assign w_v_hi = w_v_lo + (V_BITS + 1)'(LINE_W);
  assign w_v_px = {1'b0, i_v};

  assign o_hit   = r_valid && (w_h_px >= w_h_lo) && (w_h_px <= w_h_hi)
                           && (w_v_px >= w_v_lo) && (w_v_px <= w_v_hi);
  assign o_age   = r_age;
  assign o_valid = r_valid;
  assign o_h     = r_h;
  assign o_v     = r_v;

endmodule

// File: rtl/traj_ring_overlay.sv
// Paints fading boxes at the last DEPTH tracked points onto the pixel stream.
module traj_ring_overlay
  import traj_pkg::*;
#(
  parameter int unsigned     H_BITS      = H_BITS_DEF,
  parameter int unsigned     V_BITS      = V_BITS_DEF,
  parameter int unsigned     COLOR_W     = COLOR_W_DEF,
  parameter int unsigned     DEPTH       = 16,
  parameter int unsigned     LINE_W      = 3,
  parameter int unsigned     LIFE_FRAMES = 63,
  parameter logic [COLOR_W-1:0] TRAJ_COLOR = TRAJ_COLOR_DEF,
  localparam int unsigned    PTR_W       = $clog2(DEPTH),
  localparam int unsigned    CNT_W       = PTR_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [COLOR_W-1:0] i_color,
  input  logic [H_BITS-1:0]  i_h,
  input  logic [V_BITS-1:0]  i_v,
  input  logic               i_rendering,
  input  logic               i_frame_tick,
  input  logic [H_BITS-1:0]  i_pointH,
  input  logic [V_BITS-1:0]  i_pointV,
  input  logic               i_pointVAL,
  input  logic               i_clear,
  output logic [COLOR_W-1:0] o_color,
  output logic [CNT_W-1:0]   o_count
);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [COLOR_W-1:0] r_color;
  logic [PTR_W-1:0]   w_newest;
  logic               w_dup, w_push, w_refresh, w_tick;
  logic [DEPTH-1:0]   w_hit, w_valid;
  logic [7:0]         w_age   [DEPTH];
  logic [H_BITS-1:0]  w_slot_h[DEPTH];
  logic [V_BITS-1:0]  w_slot_v[DEPTH];

  assign w_newest  = r_wr_ptr - 1'b1;
  assign w_dup     = w_valid[w_newest] && (w_slot_h[w_newest] == i_pointH)
                                       && (w_slot_v[w_newest] == i_pointV);
  assign w_push    = i_pointVAL && !i_clear && !w_dup;
  assign w_refresh = i_pointVAL && !i_clear && w_dup;
  assign w_tick    = i_frame_tick && !i_clear;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    traj_slot #(
      .H_BITS     (H_BITS),
      .V_BITS     (V_BITS),
      .LINE_W     (LINE_W),
      .LIFE_FRAMES(LIFE_FRAMES)
    ) u_slot (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (i_clear),
      .i_load   (w_push && (r_wr_ptr == PTR_W'(k))),
      .i_refresh(w_refresh && (w_newest == PTR_W'(k))),
      .i_tick   (w_tick),
      .i_load_h (i_pointH),
      .i_load_v (i_pointV),
      .i_h      (i_h),
      .i_v      (i_v),
      .o_hit    (w_hit[k]),
      .o_age    (w_age[k]),
      .o_valid  (w_valid[k]),
      .o_h      (w_slot_h[k]),
      .o_v      (w_slot_v[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_wr_ptr <= '0;
    else if (i_clear) r_wr_ptr <= '0;
    else if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  always_comb begin
    o_count = '0;
    for (int k = 0; k < DEPTH; k++) o_count = o_count + CNT_W'(w_valid[k]);
  end

  logic             w_any;
  logic [7:0]       w_best_age;
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so that an equal-age later write wins the tie.
  always_comb begin
    w_any      = 1'b0;
    w_best_age = 8'hFF;
    w_idx      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_idx = r_wr_ptr + PTR_W'(j);
      if (w_hit[w_idx] && (!w_any || (w_age[w_idx] <= w_best_age))) begin
        w_any      = 1'b1;
        w_best_age = w_age[w_idx];
      end
    end
  end

  logic [15:0]        w_bucket_full;
  logic [1:0]         w_bucket;
  colour_t            w_base;
  logic [COLOR_W-1:0] w_faded;

  assign w_bucket_full = (16'(w_best_age) * 16'd4) / 16'(LIFE_FRAMES);
  assign w_bucket      = (w_bucket_full > 16'd3) ? 2'd3 : w_bucket_full[1:0];
  assign w_base        = TRAJ_COLOR;
  assign w_faded       = fade(w_base, w_bucket);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_color <= '0;
    else          r_color <= (i_rendering && w_any) ? w_faded : i_color;
  end

  assign o_color = r_color;

endmodule

// File: tb/tb_traj_ring_overlay.sv
// Directed bench for traj_ring_overlay: probe table plus multi-cycle sequences.
module tb_traj_ring_overlay;

  localparam logic [29:0] FULL  = {10'd0, 10'd800, 10'd0};
  localparam logic [29:0] HALF  = {10'd0, 10'd400, 10'd0};
  localparam logic [29:0] QUART = {10'd0, 10'd200, 10'd0};
  localparam logic [29:0] EIGHT = {10'd0, 10'd100, 10'd0};
  localparam logic [29:0] BG1   = {10'd123, 10'd45, 10'd678};
  localparam logic [29:0] BG2   = {10'd1, 10'd2, 10'd3};

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [29:0] i_color;
  logic [9:0]  i_h, i_v, i_pointH, i_pointV;
  logic        i_rendering, i_frame_tick, i_pointVAL, i_clear;
  logic [29:0] o_color;
  logic [4:0]  o_count;

  int n_cmp = 0;
  int n_bad = 0;

  traj_ring_overlay u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_color     (i_color),
    .i_h         (i_h),
    .i_v         (i_v),
    .i_rendering (i_rendering),
    .i_frame_tick(i_frame_tick),
    .i_pointH    (i_pointH),
    .i_pointV    (i_pointV),
    .i_pointVAL  (i_pointVAL),
    .i_clear     (i_clear),
    .o_color     (o_color),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        rend;
    logic [29:0] bg;
    logic [29:0] exp;
    string       name;
  } probe_t;

  probe_t tbl[10];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic push(input logic [9:0] h, input logic [9:0] v);
    i_pointH = h; i_pointV = v; i_pointVAL = 1'b1;
    step();
    i_pointVAL = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      i_frame_tick = 1'b1;
      step();
      i_frame_tick = 1'b0;
    end
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic rend,
                       input logic [29:0] bg, input logic [29:0] exp, input string name);
    i_h = h; i_v = v; i_rendering = rend; i_color = bg;
    step();
    check(name, {2'b0, o_color}, {2'b0, exp});
  endtask

  initial begin
    tbl[0] = '{h: 102, v: 53,  rend: 1, bg: BG1, exp: FULL, name: "box_inner"};
    tbl[1] = '{h: 104, v: 50,  rend: 1, bg: BG1, exp: BG1,  name: "box_right_out"};
    tbl[2] = '{h: 100, v: 50,  rend: 1, bg: BG2, exp: FULL, name: "box_corner_lo"};
    tbl[3] = '{h: 103, v: 53,  rend: 1, bg: BG2, exp: FULL, name: "box_corner_hi"};
    tbl[4] = '{h: 100, v: 54,  rend: 1, bg: BG1, exp: BG1,  name: "box_below_out"};
    tbl[5] = '{h: 99,  v: 50,  rend: 1, bg: BG2, exp: BG2,  name: "box_left_out"};
    tbl[6] = '{h: 0,   v: 478, rend: 1, bg: BG1, exp: BG1,  name: "edge_no_wrap"};
    tbl[7] = '{h: 639, v: 479, rend: 1, bg: BG2, exp: FULL, name: "edge_hit"};
    tbl[8] = '{h: 102, v: 53,  rend: 0, bg: BG1, exp: BG1,  name: "not_rendering"};
    tbl[9] = '{h: 640, v: 481, rend: 1, bg: BG1, exp: FULL, name: "edge_far_corner"};

    i_rst_n = 1'b0; i_color = BG1; i_h = '0; i_v = '0; i_rendering = 1'b1;
    i_frame_tick = 1'b0; i_pointH = '0; i_pointV = '0; i_pointVAL = 1'b0; i_clear = 1'b0;
    step();
    step();
    check("reset_color", {2'b0, o_color}, 32'd0);
    check("reset_count", {27'b0, o_count}, 32'd0);
    i_rst_n = 1'b1;

    // Basic hit test and frame-edge boxes
    push(10'd100, 10'd50);
    push(10'd637, 10'd478);
    check("count_two", {27'b0, o_count}, 32'd2);
    for (int i = 0; i < 10; i++) probe(tbl[i].h, tbl[i].v, tbl[i].rend, tbl[i].bg, tbl[i].exp,
                                       tbl[i].name);

    // Ring overwrite
    do_reset();
    for (int i = 0; i < 17; i++) push(10'(i * 20), 10'd100);
    check("full_count", {27'b0, o_count}, 32'd16);
    probe(10'd0, 10'd100, 1'b1, BG1, BG1, "oldest_overwritten");
    for (int i = 1; i < 17; i++) probe(10'(i * 20 + 1), 10'd101, 1'b1, BG1, FULL, "ring_hit");

    // Fade and expiry
    do_reset();
    push(10'd10, 10'd10);
    ticks(16);
    probe(10'd10, 10'd10, 1'b1, BG1, HALF, "fade_bucket1");
    ticks(46);
    check("count_age62", {27'b0, o_count}, 32'd1);
    probe(10'd13, 10'd13, 1'b1, BG1, EIGHT, "fade_bucket3");
    ticks(1);
    check("count_expired", {27'b0, o_count}, 32'd0);
    probe(10'd10, 10'd10, 1'b1, BG1, BG1, "expired_no_hit");

    // Youngest-hit selection
    do_reset();
    push(10'd50, 10'd300);
    ticks(32);
    push(10'd52, 10'd302);
    probe(10'd52, 10'd302, 1'b1, BG1, FULL, "youngest_wins");
    probe(10'd50, 10'd300, 1'b1, BG1, QUART, "old_only_bucket2");

    // Push together with a tick
    do_reset();
    push(10'd200, 10'd200);
    ticks(16);
    i_pointH = 10'd300; i_pointV = 10'd300; i_pointVAL = 1'b1; i_frame_tick = 1'b1;
    step();
    i_pointVAL = 1'b0; i_frame_tick = 1'b0;
    probe(10'd300, 10'd300, 1'b1, BG1, FULL, "push_tick_new");
    probe(10'd200, 10'd200, 1'b1, BG1, HALF, "push_tick_old");

    // Clear wins over push
    do_reset();
    push(10'd100, 10'd50);
    i_pointH = 10'd400; i_pointV = 10'd400; i_pointVAL = 1'b1; i_clear = 1'b1;
    step();
    i_pointVAL = 1'b0; i_clear = 1'b0;
    check("clear_count", {27'b0, o_count}, 32'd0);
    probe(10'd400, 10'd400, 1'b1, BG1, BG1, "clear_drops_push");
    probe(10'd100, 10'd50, 1'b1, BG2, BG2, "clear_drops_old");
    push(10'd400, 10'd400);
    check("after_clear_count", {27'b0, o_count}, 32'd1);

    // Dedup refreshes the newest entry
    do_reset();
    push(10'd5, 10'd5);
    ticks(16);
    push(10'd5, 10'd5);
    check("dedup_count", {27'b0, o_count}, 32'd1);
    probe(10'd5, 10'd5, 1'b1, BG1, FULL, "dedup_refresh");
    probe(10'd5, 10'd5, 1'b0, BG2, BG2, "dedup_not_rendering");

    // Reset mid-stream
    i_rst_n = 1'b0;
    i_h = 10'd5; i_v = 10'd5; i_rendering = 1'b1;
    step();
    check("midreset_color", {2'b0, o_color}, 32'd0);
    check("midreset_count", {27'b0, o_count}, 32'd0);
    i_rst_n = 1'b1;
    probe(10'd5, 10'd5, 1'b1, BG1, BG1, "midreset_no_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
